// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
// Widths, FSM encodings and requester IDs.
package mem_port_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int MASK_WIDTH_DEF = DATA_WIDTH_DEF / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational 2-way round-robin pick between IFU and LSU.
// On contention the side that did not win last time is chosen.
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic       ifu_valid_i,
    input  logic       lsu_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);

    always_comb begin
        gnt_o = 2'b00;
        win_o = REQ_IFU;
        unique case (1'b1)
            (ifu_valid_i && lsu_valid_i): begin
                win_o = (last_grant_i == REQ_LSU) ? REQ_IFU : REQ_LSU;
                gnt_o = (win_o == REQ_IFU) ? 2'b01 : 2'b10;
            end
            (ifu_valid_i && !lsu_valid_i): begin
                win_o = REQ_IFU;
                gnt_o = 2'b01;
            end
            (!ifu_valid_i && lsu_valid_i): begin
                win_o = REQ_LSU;
                gnt_o = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store units,
// one outstanding transaction, responses routed to the issuer.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_resp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [MASK_WIDTH-1:0] mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    arb_state_e            state_q, state_d;
    logic                  last_q, owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, lsu_rdata_q;
    logic                  ifu_rv_q, lsu_rv_q;

    logic [1:0] gnt;
    logic       win;
    logic       accept;
    logic       resp_hit;

    arb_rr2 u_arb (
        .ifu_valid_i  (ifu_req_valid),
        .lsu_valid_i  (lsu_req_valid),
        .last_grant_i (last_q),
        .gnt_o        (gnt),
        .win_o        (win)
    );

    assign accept   = (state_q == IDLE) && (|gnt);
    assign resp_hit = (state_q == WAIT) && mem_resp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|gnt) state_d = ISSUE;
            ISSUE:   if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready = (state_q == IDLE) && gnt[0];
        lsu_req_ready = (state_q == IDLE) && gnt[1];
        mem_req_valid = (state_q == ISSUE);
    end

    // Request fields, owner tracking and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= REQ_LSU;
            owner_q <= REQ_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            owner_q <= win;
            if (ifu_req_valid && lsu_req_valid) last_q <= win;
            if (win == REQ_LSU) begin
                addr_q  <= lsu_req_addr;
                wen_q   <= lsu_req_wen;
                wdata_q <= lsu_req_wdata;
                wmask_q <= lsu_req_wmask;
            end else begin
                addr_q  <= ifu_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // Response return; stores report zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            ifu_rv_q <= resp_hit && (owner_q == REQ_IFU);
            lsu_rv_q <= resp_hit && (owner_q == REQ_LSU);
            if (resp_hit && owner_q == REQ_IFU) ifu_rdata_q <= mem_resp_data;
            if (resp_hit && owner_q == REQ_LSU)
                lsu_rdata_q <= wen_q ? '0 : mem_resp_data;
        end
    end

    assign ifu_resp_valid = ifu_rv_q;
    assign ifu_resp_data  = ifu_rdata_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign lsu_resp_data  = lsu_rdata_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Expected values are hand-computed per vector.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int vectors;
    int miscompares;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_req_addr  = '0;
        lsu_req_valid = 1'b0;
        lsu_req_addr  = '0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = '0;
        lsu_req_wmask = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;

        #12;
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_ifu_rdy", ifu_req_ready, 0);
        chk("rst_lsu_rdy", lsu_req_ready, 0);
        chk("rst_ifu_rv", ifu_resp_valid, 0);
        chk("rst_lsu_rv", lsu_resp_valid, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_wmask", mem_req_wmask, 0);
        #10;
        rst_n = 1'b1;
        tick();

        // Contention from reset: IFU, LSU, IFU, LSU
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0100;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h0000_0200;
        lsu_req_wen   = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = i[0];
            chk("ctn_ifu_rdy", ifu_req_ready, !exp_lsu);
            chk("ctn_lsu_rdy", lsu_req_ready, exp_lsu);
            tick();
            mem_req_ready = 1'b1;
            #1;
            chk("ctn_issue_rdy", {ifu_req_ready, lsu_req_ready}, 0);
            chk("ctn_addr", mem_req_addr,
                exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hA0 + i;
            #1;
            chk("ctn_wait_rdy", {ifu_req_ready, lsu_req_ready}, 0);
            tick();
            mem_resp_valid = 1'b0;
            if (i == 3) begin
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
            end
            #1;
            chk("ctn_ifu_rv", ifu_resp_valid, !exp_lsu);
            chk("ctn_lsu_rv", lsu_resp_valid, exp_lsu);
            if (exp_lsu) chk("ctn_lsu_data", lsu_resp_data, 32'hA0 + i);
            else         chk("ctn_ifu_data", ifu_resp_data, 32'hA0 + i);
        end
        tick();

        // IFU only, zero-wait memory
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        #1;
        chk("ifu_rdy", ifu_req_ready, 1);
        chk("ifu_lsu_rdy", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("ifu_mem_valid", mem_req_valid, 1);
        chk("ifu_mem_addr", mem_req_addr, 32'h8000_0000);
        chk("ifu_mem_wen", mem_req_wen, 0);
        chk("ifu_mem_wmask", mem_req_wmask, 0);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0413;
        #1;
        chk("ifu_wait_mv", mem_req_valid, 0);
        chk("ifu_early_rv", ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("ifu_rv", ifu_resp_valid, 1);
        chk("ifu_data", ifu_resp_data, 32'h0000_0413);
        chk("ifu_lsu_rv", lsu_resp_valid, 0);
        tick();
        chk("ifu_rv_pulse", ifu_resp_valid, 0);
        chk("ifu_data_hold", ifu_resp_data, 32'h0000_0413);

        // LSU store
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 4'hF;
        #1;
        chk("st_rdy", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_req_wdata = 32'h0;
        mem_req_ready = 1'b1;
        #1;
        chk("st_addr", mem_req_addr, 32'h8000_1000);
        chk("st_wen", mem_req_wen, 1);
        chk("st_wdata", mem_req_wdata, 32'hDEAD_BEEF);
        chk("st_wmask", mem_req_wmask, 4'hF);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        lsu_req_wen    = 1'b0;
        #1;
        chk("st_rv", lsu_resp_valid, 1);
        chk("st_data", lsu_resp_data, 0);
        chk("st_ifu_rv", ifu_resp_valid, 0);
        tick();

        // Memory backpressure, LSU waits behind IFU
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0040;
        #1;
        chk("bp_ifu_rdy", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h0000_0300;
        for (int k = 0; k < 6; k++) begin
            mem_req_ready = (k == 5);
            #1;
            chk("bp_mem_valid", mem_req_valid, 1);
            chk("bp_addr", mem_req_addr, 32'h8000_0040);
            chk("bp_wen_mask", {mem_req_wen, mem_req_wmask}, 0);
            chk("bp_rdy", {ifu_req_ready, lsu_req_ready}, 0);
            tick();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0055;
        #1;
        chk("bp_wait_rdy", lsu_req_ready, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("bp_ifu_rv", ifu_resp_valid, 1);
        chk("bp_ifu_data", ifu_resp_data, 32'h0000_0055);
        chk("bp_lsu_b2b", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("bp_lsu_addr", mem_req_addr, 32'h0000_0300);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0066;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("bp_lsu_rv", lsu_resp_valid, 1);
        chk("bp_lsu_data", lsu_resp_data, 32'h0000_0066);
        tick();
        chk("bp_lsu_pulse", lsu_resp_valid, 0);

        // Spurious responses
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_0001;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("sp_idle_rv", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("sp_idle_mv", mem_req_valid, 0);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0080;
        #1;
        chk("sp_ifu_rdy", ifu_req_ready, 1);
        tick();
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        #1;
        chk("sp_issue_hold", mem_req_valid, 1);
        chk("sp_issue_rv", ifu_resp_valid, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("sp_wait_mv", mem_req_valid, 0);
        tick();
        chk("sp_hs_rv", ifu_resp_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0777;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("sp_real_rv", ifu_resp_valid, 1);
        chk("sp_real_data", ifu_resp_data, 32'h0000_0777);
        tick();

        // Reset while waiting for a response
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h0000_0400;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'h0000_1111;
        lsu_req_wmask = 4'h3;
        tick();
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw_mem_valid", mem_req_valid, 0);
        chk("rw_addr", mem_req_addr, 0);
        chk("rw_wdata", mem_req_wdata, 0);
        chk("rw_ifu_data", ifu_resp_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0888;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rw_no_rv", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rw_idle_mv", mem_req_valid, 0);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        #1;
        chk("rw_ifu_rdy", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("rw_ifu_addr", mem_req_addr, 32'h8000_0000);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0999;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rw_ifu_rv", ifu_resp_valid, 1);
        chk("rw_ifu_data2", ifu_resp_data, 32'h0000_0999);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
